// File: rtl/store_stage_pkg.sv
// Shared types and helpers for the store stage: op/state encodings, the physical
// address type, the fetch notification record and byte-lane helpers.
package store_stage_pkg;

  localparam int PHYS_ADDR_W = 21;

  typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_STORE = 2'd1,
    OP_JUMP  = 2'd2,
    OP_RSVD  = 2'd3
  } store_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_NOTIFY   = 2'd3
  } store_state_t;

  typedef struct packed {
    logic                 redirect;
    logic                 error;
    phys_memory_address_t pc;
  } store_to_fetch_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Wide enough that an offset mask spilling past lane 7 stays visible to callers.
  function automatic logic [15:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
    return ((16'd1 << size_bytes(size)) - 16'd1) << offset;
  endfunction

endpackage

// File: rtl/store_stage_lane_align.sv
// Combinational lane placement for a store: byte enables, shifted data and the
// flag for stores that would cross an 8-byte line.
module store_lane_align
  import store_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]          size,
  input  logic [2:0]          offset,
  input  logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   data_shifted,
  output logic                misaligned
);

  localparam int LANES = DATA_W / 8;

  logic [15:0] mask;

  assign mask         = be_mask(size, offset);
  assign be           = LANES'(mask);
  assign data_shifted = data << {offset, 3'b000};
  assign misaligned   = ({1'b0, offset} + size_bytes(size)) > 4'd8;

endmodule

// File: rtl/store_stage.sv
// Final pipeline stage: performs stores on the shared memory bus and reports
// retire/redirect to fetch. One instruction in flight, strictly in order.
//
//  state       | meaning
//  ------------+--------------------------------------------------------------
//  ST_IDLE     | ex_ready high, waiting for an execute result
//  ST_ISSUE    | write request on the bus, held until mem_req_ready
//  ST_WAIT_ACK | request accepted, counting down to the ack timeout
//  ST_NOTIFY   | retire record to fetch, held until sf_ready
module store_stage
  import store_stage_pkg::*;
#(
  parameter int core_id        = 0,
  parameter int ADDR_W         = 21,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [1:0]          ex_op,
  input  logic [1:0]          ex_size,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_data,
  output logic [DATA_W/8-1:0] mem_req_be,
  output logic [7:0]          mem_req_core,
  input  logic                mem_ack,
  output logic                sf_valid,
  input  logic                sf_ready,
  output logic                sf_redirect,
  output logic [ADDR_W-1:0]   sf_pc,
  output logic                sf_error,
  output logic [31:0]         retired_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  store_state_t    state, state_nxt;
  store_op_t       op_in;
  store_to_fetch_t sf_q, sf_nxt;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [TW-1:0]       timer_q, timer_nxt;
  logic [31:0]         retired_q;
  logic                accept, retire;

  logic [1:0]          al_size;
  logic [2:0]          al_offset;
  logic [DATA_W/8-1:0] al_be;
  logic [DATA_W-1:0]   al_data;
  logic                al_misaligned;

  assign op_in = store_op_t'(ex_op);

  // In IDLE the aligner looks at the incoming result so misalignment is known at accept.
  assign al_size   = (state == ST_IDLE) ? ex_size      : size_q;
  assign al_offset = (state == ST_IDLE) ? ex_addr[2:0] : addr_q[2:0];

  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .size         (al_size),
    .offset       (al_offset),
    .data         (data_q),
    .be           (al_be),
    .data_shifted (al_data),
    .misaligned   (al_misaligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      sf_q      <= '0;
      timer_q   <= '0;
      size_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      retired_q <= '0;
    end else begin
      state   <= state_nxt;
      sf_q    <= sf_nxt;
      timer_q <= timer_nxt;
      if (accept) begin
        size_q <= ex_size;
        addr_q <= ex_addr;
        data_q <= ex_data;
      end
      if (retire) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    sf_nxt        = sf_q;
    timer_nxt     = timer_q;
    ex_ready      = 1'b0;
    mem_req_valid = 1'b0;
    sf_valid      = 1'b0;
    accept        = 1'b0;
    retire        = 1'b0;
    case (state)
      ST_IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid) begin
          accept = 1'b1;
          sf_nxt = '0;
          case (op_in)
            OP_STORE: begin
              if (al_misaligned) begin
                sf_nxt.error = 1'b1;
                state_nxt    = ST_NOTIFY;
              end else begin
                state_nxt = ST_ISSUE;
              end
            end
            OP_JUMP: begin
              sf_nxt.redirect = 1'b1;
              sf_nxt.pc       = PHYS_ADDR_W'(ex_addr);
              state_nxt       = ST_NOTIFY;
            end
            default: state_nxt = ST_NOTIFY;
          endcase
        end
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          timer_nxt = TW'(TIMEOUT_CYCLES - 1);
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // An ack on the final timer cycle still counts as a clean completion.
        if (mem_ack) begin
          state_nxt = ST_NOTIFY;
        end else if (timer_q == '0) begin
          sf_nxt.error = 1'b1;
          state_nxt    = ST_NOTIFY;
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
      ST_NOTIFY: begin
        sf_valid = 1'b1;
        if (sf_ready) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_req_addr  = mem_req_valid ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_req_data  = mem_req_valid ? al_data : '0;
  assign mem_req_be    = mem_req_valid ? al_be : '0;
  assign mem_req_core  = mem_req_valid ? 8'(core_id) : 8'd0;

  assign sf_redirect   = sf_valid & sf_q.redirect;
  assign sf_error      = sf_valid & sf_q.error;
  assign sf_pc         = sf_valid ? ADDR_W'(sf_q.pc) : '0;
  assign retired_count = retired_q;

endmodule
